// File: rtl/pmem_arbiter.sv
// Program RAM arbiter: CPU fetch port vs. serial bootloader port.
// One-entry write buffer; drains, holds and releases the CPU around loading.
module pmem_arbiter #(
  parameter int ADDR_WIDTH     = 16,
  parameter int RELEASE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  output logic [15:0]           cpu_rdata,
  output logic                  cpu_valid,
  output logic                  cpu_stall,
  output logic                  cpu_hold_rst,
  input  logic                  ldr_mode,
  input  logic [ADDR_WIDTH-1:0] ldr_addr,
  input  logic [15:0]           ldr_wdata,
  input  logic                  ldr_we_low,
  input  logic                  ldr_we_high,
  output logic [15:0]           ldr_rdata,
  output logic                  mem_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [15:0]           mem_wdata,
  output logic [1:0]            mem_we,
  input  logic [15:0]           mem_rdata
);

  typedef enum logic [1:0] {
    CPU_RUN,
    DRAIN,
    LOADER,
    RELEASE
  } state_t;

  // A zero delay would never leave RELEASE cleanly; treat it as one.
  localparam logic [7:0] REL_INIT =
    (RELEASE_CYCLES < 1) ? 8'd1 : 8'(RELEASE_CYCLES);

  state_t                state;
  state_t                state_nx;
  logic [7:0]            cnt;
  logic                  pend;
  logic [ADDR_WIDTH-1:0] wb_addr;
  logic [15:0]           wb_data;
  logic [1:0]            wb_lanes;
  logic                  cpu_grant;
  logic                  valid_q;
  logic [15:0]           rdata_q;
  logic [15:0]           ldr_rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= CPU_RUN;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      CPU_RUN: if (ldr_mode) state_nx = DRAIN;
      DRAIN:   state_nx = LOADER;
      LOADER:  if (!ldr_mode) state_nx = RELEASE;
      RELEASE: begin
        if (ldr_mode) begin
          state_nx = LOADER;
        end else if (cnt <= 8'd1) begin
          state_nx = CPU_RUN;
        end
      end
      default: state_nx = CPU_RUN;
    endcase
  end

  always_comb begin
    cpu_grant    = 1'b0;
    cpu_stall    = 1'b0;
    cpu_hold_rst = (state != CPU_RUN);
    mem_en       = 1'b0;
    mem_we       = 2'b00;
    mem_addr     = ldr_addr;
    mem_wdata    = wb_data;
    if (pend) begin
      mem_en   = 1'b1;
      mem_we   = wb_lanes;
      mem_addr = wb_addr;
    end
    unique case (state)
      CPU_RUN: begin
        if (cpu_req && pend) begin
          cpu_stall = 1'b1;
        end else if (cpu_req) begin
          cpu_grant = 1'b1;
          mem_en    = 1'b1;
          mem_addr  = cpu_addr;
        end
      end
      default: begin
        cpu_stall = 1'b1;
        if (!pend) mem_en = 1'b1;
      end
    endcase
    // Outputs stay quiet for the whole reset pulse, not just after it.
    if (rst) begin
      cpu_grant    = 1'b0;
      cpu_stall    = 1'b0;
      cpu_hold_rst = 1'b0;
      mem_en       = 1'b0;
      mem_we       = 2'b00;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 8'd0;
    end else if (state == LOADER && !ldr_mode) begin
      cnt <= REL_INIT;
    end else if (state == RELEASE) begin
      if (ldr_mode || cnt <= 8'd1) begin
        cnt <= 8'd0;
      end else begin
        cnt <= cnt - 8'd1;
      end
    end
  end

  // Capture on every strobe; the previous entry issues this same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend     <= 1'b0;
      wb_addr  <= '0;
      wb_data  <= 16'h0000;
      wb_lanes <= 2'b00;
    end else if (ldr_we_low || ldr_we_high) begin
      pend     <= 1'b1;
      wb_addr  <= ldr_addr;
      wb_data  <= ldr_wdata;
      wb_lanes <= {ldr_we_high, ldr_we_low};
    end else begin
      pend     <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= 1'b0;
      rdata_q     <= 16'h0000;
      ldr_rdata_q <= 16'h0000;
    end else begin
      valid_q <= cpu_grant;
      if (valid_q) rdata_q <= mem_rdata;
      if (state != CPU_RUN) ldr_rdata_q <= mem_rdata;
    end
  end

  assign cpu_valid = valid_q;
  assign cpu_rdata = valid_q ? mem_rdata : rdata_q;
  assign ldr_rdata = ldr_rdata_q;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter with a byte-lane RAM model.
// Vector table for the main flow, hand sequences for release and reset.
module tb_pmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_rdata;
  logic        cpu_valid;
  logic        cpu_stall;
  logic        cpu_hold_rst;
  logic        ldr_mode;
  logic [15:0] ldr_addr;
  logic [15:0] ldr_wdata;
  logic        ldr_we_low;
  logic        ldr_we_high;
  logic [15:0] ldr_rdata;
  logic        mem_en;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [1:0]  mem_we;
  logic [15:0] mem_rdata;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pmem_arbiter #(.ADDR_WIDTH(16), .RELEASE_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .cpu_rdata(cpu_rdata), .cpu_valid(cpu_valid),
    .cpu_stall(cpu_stall), .cpu_hold_rst(cpu_hold_rst),
    .ldr_mode(ldr_mode), .ldr_addr(ldr_addr),
    .ldr_wdata(ldr_wdata), .ldr_we_low(ldr_we_low),
    .ldr_we_high(ldr_we_high), .ldr_rdata(ldr_rdata),
    .mem_en(mem_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  logic [15:0] ram [0:1023];

  always_ff @(posedge clk) begin
    if (mem_en) begin
      if (mem_we[0]) ram[mem_addr[9:0]][7:0]  <= mem_wdata[7:0];
      if (mem_we[1]) ram[mem_addr[9:0]][15:8] <= mem_wdata[15:8];
      mem_rdata <= ram[mem_addr[9:0]];
    end
  end

  typedef struct {
    logic        req;
    logic [15:0] caddr;
    logic        mode;
    logic [15:0] laddr;
    logic [15:0] wd;
    logic        wl;
    logic        wh;
    logic        stall;
    logic        valid;
    logic        hold;
    logic        en;
    logic [1:0]  we;
    logic [15:0] crd;
    logic        chk_l;
    logic [15:0] lrd;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic count_hold(input string n);
    int c;
    int bad;
    c   = 0;
    bad = 0;
    while (cpu_hold_rst && c < 100) begin
      c++;
      if (cpu_valid) bad++;
      tick();
    end
    chk({n, "_cycles"}, c, 16);
    chk({n, "_no_valid"}, bad, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 16'h0000;
    ram[16'h010] = 16'h940C;
    ram[16'h020] = 16'h1234;
    ram[16'h030] = 16'hBEEF;
    ram[16'h300] = 16'hABCD;

    vecs[0]  = '{1, 16'h10, 0, 16'h000, 16'h0000, 0, 0,
                 0, 0, 0, 1, 2'b00, 16'h0000, 0, 16'h0};
    vecs[1]  = '{0, 16'h10, 0, 16'h000, 16'h0000, 0, 0,
                 0, 1, 0, 0, 2'b00, 16'h940C, 0, 16'h0};
    vecs[2]  = '{0, 16'h10, 0, 16'h000, 16'h0000, 0, 0,
                 0, 0, 0, 0, 2'b00, 16'h940C, 0, 16'h0};
    vecs[3]  = '{1, 16'h20, 1, 16'h100, 16'h0000, 0, 0,
                 0, 0, 0, 1, 2'b00, 16'h940C, 0, 16'h0};
    vecs[4]  = '{1, 16'h20, 1, 16'h100, 16'h0000, 0, 0,
                 1, 1, 1, 1, 2'b00, 16'h1234, 0, 16'h0};
    vecs[5]  = '{0, 16'h20, 1, 16'h100, 16'h5A5A, 1, 0,
                 1, 0, 1, 1, 2'b00, 16'h1234, 0, 16'h0};
    vecs[6]  = '{0, 16'h20, 1, 16'h100, 16'h5A5A, 0, 0,
                 1, 0, 1, 1, 2'b01, 16'h1234, 0, 16'h0};
    vecs[7]  = '{0, 16'h20, 1, 16'h100, 16'hC3C3, 0, 1,
                 1, 0, 1, 1, 2'b00, 16'h1234, 0, 16'h0};
    vecs[8]  = '{0, 16'h20, 1, 16'h100, 16'hC3C3, 0, 0,
                 1, 0, 1, 1, 2'b10, 16'h1234, 0, 16'h0};
    vecs[9]  = '{0, 16'h20, 1, 16'h100, 16'h0000, 0, 0,
                 1, 0, 1, 1, 2'b00, 16'h1234, 0, 16'h0};
    vecs[10] = '{0, 16'h20, 1, 16'h100, 16'h0000, 0, 0,
                 1, 0, 1, 1, 2'b00, 16'h1234, 0, 16'h0};
    vecs[11] = '{0, 16'h20, 1, 16'h100, 16'h0000, 0, 0,
                 1, 0, 1, 1, 2'b00, 16'h1234, 1, 16'hC35A};

    rst         = 1'b1;
    cpu_req     = 1'b1;
    cpu_addr    = 16'h0010;
    ldr_mode    = 1'b0;
    ldr_addr    = 16'h0000;
    ldr_wdata   = 16'h0000;
    ldr_we_low  = 1'b0;
    ldr_we_high = 1'b0;
    #3;
    chk("rst_mem_en", mem_en, 0);
    chk("rst_stall", cpu_stall, 0);
    chk("rst_hold", cpu_hold_rst, 0);
    chk("rst_valid", cpu_valid, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_ldr_rdata", ldr_rdata, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      cpu_req     = vecs[i].req;
      cpu_addr    = vecs[i].caddr;
      ldr_mode    = vecs[i].mode;
      ldr_addr    = vecs[i].laddr;
      ldr_wdata   = vecs[i].wd;
      ldr_we_low  = vecs[i].wl;
      ldr_we_high = vecs[i].wh;
      #1;
      chk($sformatf("v%0d_stall", i), cpu_stall, vecs[i].stall);
      chk($sformatf("v%0d_valid", i), cpu_valid, vecs[i].valid);
      chk($sformatf("v%0d_hold", i), cpu_hold_rst, vecs[i].hold);
      chk($sformatf("v%0d_en", i), mem_en, vecs[i].en);
      chk($sformatf("v%0d_we", i), mem_we, vecs[i].we);
      chk($sformatf("v%0d_crd", i), cpu_rdata, vecs[i].crd);
      if (vecs[i].chk_l)
        chk($sformatf("v%0d_lrd", i), ldr_rdata, vecs[i].lrd);
      tick();
    end

    ldr_mode = 1'b0;
    tick();
    count_hold("release");
    chk("release_run", cpu_hold_rst, 0);

    ldr_mode = 1'b1;
    tick();
    tick();
    ldr_mode = 1'b0;
    tick();
    for (int i = 1; i < 8; i++) tick();
    ldr_mode = 1'b1;
    tick();
    chk("reenter_hold", cpu_hold_rst, 1);
    tick();
    chk("reenter_hold2", cpu_hold_rst, 1);
    ldr_mode = 1'b0;
    tick();
    count_hold("rerelease");

    cpu_req  = 1'b1;
    cpu_addr = 16'h0030;
    #1;
    chk("run_stall0", cpu_stall, 0);
    chk("run_addr0", mem_addr, 16'h0030);
    tick();
    ldr_we_high = 1'b1;
    ldr_addr    = 16'h0200;
    ldr_wdata   = 16'h7E7E;
    #1;
    chk("strb_stall", cpu_stall, 0);
    chk("strb_we", mem_we, 2'b00);
    tick();
    ldr_we_high = 1'b0;
    #1;
    chk("issue_stall", cpu_stall, 1);
    chk("issue_we", mem_we, 2'b10);
    chk("issue_addr", mem_addr, 16'h0200);
    chk("issue_valid", cpu_valid, 1);
    chk("issue_rdata", cpu_rdata, 16'hBEEF);
    tick();
    chk("resume_stall", cpu_stall, 0);
    chk("resume_we", mem_we, 2'b00);
    chk("resume_addr", mem_addr, 16'h0030);
    chk("resume_novalid", cpu_valid, 0);
    tick();
    chk("resume_valid", cpu_valid, 1);
    chk("resume_rdata", cpu_rdata, 16'hBEEF);
    chk("ram_200", ram[16'h200], 16'h7E00);

    cpu_addr   = 16'h0010;
    ldr_we_low = 1'b1;
    ldr_addr   = 16'h0300;
    ldr_wdata  = 16'h1111;
    tick();
    ldr_we_low = 1'b0;
    #1;
    chk("pre_rst_we", mem_we, 2'b01);
    chk("pre_rst_stall", cpu_stall, 1);
    rst = 1'b1;
    #1;
    chk("arst_we", mem_we, 2'b00);
    chk("arst_en", mem_en, 0);
    chk("arst_stall", cpu_stall, 0);
    chk("arst_valid", cpu_valid, 0);
    chk("arst_hold", cpu_hold_rst, 0);
    chk("arst_crd", cpu_rdata, 0);
    chk("arst_lrd", ldr_rdata, 0);
    tick();
    rst = 1'b0;
    chk("ram_300", ram[16'h300], 16'hABCD);
    #1;
    chk("post_stall", cpu_stall, 0);
    chk("post_en", mem_en, 1);
    chk("post_addr", mem_addr, 16'h0010);
    chk("post_we", mem_we, 2'b00);
    tick();
    chk("post_valid", cpu_valid, 1);
    chk("post_rdata", cpu_rdata, 16'h940C);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
